clint: RTL and testbench
========================

CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL: one clock, clk; reset rst is synchronous and active-high.
REQ-002 SHALL: clk  input  1  core clock.
REQ-003 SHALL: rst  input  1  synchronous active-high reset.
REQ-004 SHALL: inst_i  input  32  instruction currently in execute.
REQ-005 SHALL: inst_addr_i  input  32  PC of inst_i.
REQ-006 SHALL: jump_flag_i  input  1  execute is taking a jump or branch this cycle.
REQ-007 SHALL: jump_addr_i  input  32  jump or branch target.
REQ-008 SHALL: int_flag_i  input  8  external interrupt requests; bit0 is the timer.
REQ-009 SHALL: global_int_en_i  input  1  mstatus.MIE from the CSR file.
REQ-010 SHALL: csr_mtvec_i, csr_mepc_i, csr_mstatus_i  input  32 each  live CSR values.
REQ-011 SHALL: we_o  output  1  CSR write strobe.
REQ-012 SHALL: waddr_o  output  32  CSR write address; bits [11:0] are significant, upper bits 0.
REQ-013 SHALL: data_o  output  32  CSR write data.
REQ-014 SHALL: hold_flag_o  output  1  stalls the pipeline.
REQ-015 SHALL: int_assert_o  output  1  one-cycle redirect pulse.
REQ-016 SHALL: int_addr_o  output  32  redirect target.

Function
REQ-017 SHALL: decode ECALL=0x00000073, EBREAK=0x00100073 and MRET=0x30200073; async request = (int_flag_i != 0) AND global_int_en_i.
REQ-018 SHALL: priority in IDLE is sync exception > MRET > async interrupt; a request is accepted only in IDLE.
REQ-019 SHALL: FSM states are IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET and ASSERT.
REQ-020 SHALL: trap path is IDLE -> W_MEPC -> W_MCAUSE -> W_MSTATUS -> ASSERT -> IDLE, with exactly one CSR write per W_* state.
REQ-021 SHALL: latched mepc for a sync trap = inst_addr_i; for async = jump_addr_i if jump_flag_i, else inst_addr_i; latching happens at acceptance.
REQ-022 SHALL: mcause = 11 for ECALL, 3 for EBREAK, 0x80000007 for async with int_flag_i[0], otherwise 0x8000000B.
REQ-023 SHALL: the W_MSTATUS trap write = csr_mstatus_i with bit7 (MPIE) <= bit3 (MIE) and bit3 <= 0.
REQ-024 SHALL: MRET path is IDLE -> W_MRET -> ASSERT -> IDLE; the write = csr_mstatus_i with bit3 <= bit7 and bit7 <= 1.
REQ-025 SHALL: in ASSERT, int_assert_o = 1 for exactly one cycle; int_addr_o = {csr_mtvec_i[31:2],2'b00} for a trap, csr_mepc_i for MRET; both are 0 otherwise.
REQ-026 SHALL: hold_flag_o = 1 combinationally in the acceptance cycle and in every non-IDLE state, and 0 in IDLE with no request.
REQ-027 SHALL: we_o = 1 only in the W_* states; waddr_o is 0x341, 0x342, 0x300 or 0x300 respectively; we_o, waddr_o and data_o are 0 elsewhere.
REQ-028 SHALL: int_flag_i changes after acceptance are ignored until return to IDLE; an interrupt still pending then is accepted only if global_int_en_i = 1.

Reset
REQ-029 SHALL: rst high at a clk edge forces IDLE and clears the latched mepc and cause, including mid-sequence; all outputs read 0 in the following cycle with no partial CSR write.

Configuration
REQ-030 SHALL: with CLINT_VECTORED_EN defined, async traps with csr_mtvec_i[1:0] = 01 redirect to {mtvec[31:2],2'b00} + 4*(mcause[30:0]); sync traps and mode 00 use the base address.
REQ-031 SHALL: with CLINT_VECTORED_EN undefined, every trap redirects to the base address and mtvec[1:0] is ignored.

Structure
REQ-032 SHALL: define.v hold the instruction encodings, the CSR addresses (CSR_MEPC, CSR_MCAUSE, CSR_MSTATUS, CSR_MTVEC), the cause codes and the FSM state encodings.
REQ-033 SHALL: clint is a single module with no sub-modules.

Verification
REQ-034 SHALL: ECALL at 0x100, mtvec=0x200, mstatus=0x8 -> writes 0x341<=0x100, 0x342<=11, 0x300<=0x80; int_assert_o with int_addr_o=0x200; hold high for 5 cycles.
REQ-035 SHALL: MRET, mepc=0x104, mstatus=0x80 -> write 0x300<=0x88, then int_addr_o=0x104.
REQ-036 SHALL: int_flag_i=0x01, global_int_en_i=1, jump_flag_i=1, jump_addr_i=0x300 -> mepc<=0x300, mcause<=0x80000007.
REQ-037 SHALL: int_flag_i=0x02 with global_int_en_i=0 -> no write, no hold, no assert.
REQ-038 SHALL: rst asserted in W_MCAUSE -> we_o=0 and hold_flag_o=0 next cycle, and no int_assert_o.
REQ-039 SHALL: with CLINT_VECTORED_EN, mtvec=0x201 and timer interrupt -> int_addr_o=0x21C; without it -> 0x200.

Source files
------------

// File: rtl/clint_pkg.sv
// Core-local interrupt controller: instruction encodings, CSR addresses,
// cause codes, FSM state encoding and mstatus update helpers.
package clint_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned IRQ_W  = 8;

  localparam logic [XLEN-1:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [XLEN-1:0] INST_MRET   = 32'h3020_0073;

  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;

  localparam logic [XLEN-1:0] CAUSE_ECALL  = 32'd11;
  localparam logic [XLEN-1:0] CAUSE_EBREAK = 32'd3;
  localparam logic [XLEN-1:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [XLEN-1:0] CAUSE_EXT    = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MSTATUS = 3'd3,
    S_W_MRET    = 3'd4,
    S_ASSERT    = 3'd5
  } clint_state_e;

  // Trap entry: MPIE takes MIE, MIE is cleared.
  function automatic logic [XLEN-1:0] mstatus_trap(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE takes MPIE, MPIE is set.
  function automatic logic [XLEN-1:0] mstatus_mret(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_if.sv
// Execute-stage / CSR-file side signals of the CLINT.
interface clint_if;
  import clint_pkg::*;

  logic [XLEN-1:0]  inst_i;
  logic [XLEN-1:0]  inst_addr_i;
  logic             jump_flag_i;
  logic [XLEN-1:0]  jump_addr_i;
  logic [IRQ_W-1:0] int_flag_i;
  logic             global_int_en_i;
  logic [XLEN-1:0]  csr_mtvec_i;
  logic [XLEN-1:0]  csr_mepc_i;
  logic [XLEN-1:0]  csr_mstatus_i;
  logic             we_o;
  logic [XLEN-1:0]  waddr_o;
  logic [XLEN-1:0]  data_o;
  logic             hold_flag_o;
  logic             int_assert_o;
  logic [XLEN-1:0]  int_addr_o;

  modport master (
    output inst_i, inst_addr_i, jump_flag_i, jump_addr_i, int_flag_i,
           global_int_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    input  we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
  );

  modport slave (
    input  inst_i, inst_addr_i, jump_flag_i, jump_addr_i, int_flag_i,
           global_int_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    output we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
  );
endinterface

// File: rtl/clint.sv
// CLINT: accepts ECALL/EBREAK, MRET and external interrupts, writes
// mepc/mcause/mstatus over successive cycles and pulses a redirect.
// Optional feature: define CLINT_VECTORED_EN for vectored async traps.
module clint
  import clint_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  clint_if.slave bus
);

  clint_state_e    state_q, state_d;
  logic [XLEN-1:0] mepc_q, cause_q;
  logic            mret_q;

  logic            is_ecall, is_ebreak, is_mret, sync_req, async_req, any_req;
  logic            we, hold, int_assert;
  logic [XLEN-1:0] waddr, wdata, int_addr, trap_addr;

  assign is_ecall  = (bus.inst_i == INST_ECALL);
  assign is_ebreak = (bus.inst_i == INST_EBREAK);
  assign is_mret   = (bus.inst_i == INST_MRET);
  assign sync_req  = is_ecall | is_ebreak;
  assign async_req = (bus.int_flag_i != IRQ_W'(0)) & bus.global_int_en_i;
  assign any_req   = (state_q == S_IDLE) & ~rst & (sync_req | is_mret | async_req);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Latch return address, cause and trap/return kind at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_q  <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (sync_req) begin
        mepc_q  <= bus.inst_addr_i;
        cause_q <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
        mret_q  <= 1'b0;
      end else if (is_mret) begin
        mret_q  <= 1'b1;
      end else if (async_req) begin
        mepc_q  <= bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;
        cause_q <= bus.int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
        mret_q  <= 1'b0;
      end
    end
  end

  // Next-state logic: sync exception > MRET > async interrupt
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sync_req)       state_d = S_W_MEPC;
        else if (is_mret)   state_d = S_W_MRET;
        else if (async_req) state_d = S_W_MEPC;
      end
      S_W_MEPC:    state_d = S_W_MCAUSE;
      S_W_MCAUSE:  state_d = S_W_MSTATUS;
      S_W_MSTATUS: state_d = S_ASSERT;
      S_W_MRET:    state_d = S_ASSERT;
      S_ASSERT:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Trap target: base address, or vector slot for async traps in mode 01
  always_comb begin
    trap_addr = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
`ifdef CLINT_VECTORED_EN
    if (bus.csr_mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1])
      trap_addr = {bus.csr_mtvec_i[XLEN-1:2], 2'b00} + {cause_q[XLEN-3:0], 2'b00};
`endif
  end

`ifndef CLINT_VECTORED_EN
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.csr_mtvec_i[1:0];
`endif

  // Output decode from state
  always_comb begin
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    int_assert = 1'b0;
    int_addr   = '0;
    hold       = (state_q != S_IDLE) | any_req;
    case (state_q)
      S_W_MEPC: begin
        we    = 1'b1;
        waddr = XLEN'(CSR_MEPC);
        wdata = mepc_q;
      end
      S_W_MCAUSE: begin
        we    = 1'b1;
        waddr = XLEN'(CSR_MCAUSE);
        wdata = cause_q;
      end
      S_W_MSTATUS: begin
        we    = 1'b1;
        waddr = XLEN'(CSR_MSTATUS);
        wdata = mstatus_trap(bus.csr_mstatus_i);
      end
      S_W_MRET: begin
        we    = 1'b1;
        waddr = XLEN'(CSR_MSTATUS);
        wdata = mstatus_mret(bus.csr_mstatus_i);
      end
      S_ASSERT: begin
        int_assert = 1'b1;
        int_addr   = mret_q ? bus.csr_mepc_i : trap_addr;
      end
      default: ;
    endcase
  end

  assign bus.we_o         = we;
  assign bus.waddr_o      = waddr;
  assign bus.data_o       = wdata;
  assign bus.hold_flag_o  = hold;
  assign bus.int_assert_o = int_assert;
  assign bus.int_addr_o   = int_addr;

endmodule

// File: tb/tb_clint.sv
// Randomized self-checking bench for clint against a transaction-level model.
module tb_clint;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clint_if bus();
  clint dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] data;
    logic        hold;
    logic        asrt;
    logic [31:0] addr;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".we"},     32'(bus.we_o),         32'(e.we));
    chk({tag, ".waddr"},  bus.waddr_o,           e.waddr);
    chk({tag, ".data"},   bus.data_o,            e.data);
    chk({tag, ".hold"},   32'(bus.hold_flag_o),  32'(e.hold));
    chk({tag, ".assert"}, 32'(bus.int_assert_o), 32'(e.asrt));
    chk({tag, ".addr"},   bus.int_addr_o,        e.addr);
  endtask

  function automatic logic [31:0] junk_inst();
    logic [31:0] t [4];
    t[0] = 32'h0000_0073; t[1] = 32'h3020_0073; t[2] = 32'h0010_0073; t[3] = $urandom;
    return t[$urandom_range(0, 3)];
  endfunction

  // One transaction: model builds the per-cycle expectation, then drive/compare
  task automatic run_txn(input string name, input logic [31:0] inst, input logic [31:0] pc,
                         input logic jf, input logic [31:0] ja, input logic [7:0] flags,
                         input logic en, input logic [31:0] mtvec, input logic [31:0] mepc_csr,
                         input logic [31:0] mstatus);
    exp_t q[$];
    exp_t e;
    logic sync_t, mret_t, async_t;
    logic [31:0] mepc, cause, tgt;
    sync_t  = (inst == 32'h0000_0073) || (inst == 32'h0010_0073);
    mret_t  = !sync_t && (inst == 32'h3020_0073);
    async_t = !sync_t && !mret_t && (flags != 8'd0) && en;
    e = '0;
    e.hold = sync_t | mret_t | async_t;
    q.push_back(e);
    if (sync_t || async_t) begin
      mepc = (async_t && jf) ? ja : pc;
      if (inst == 32'h0000_0073) cause = 32'd11;
      else if (sync_t)           cause = 32'd3;
      else if (flags[0])         cause = 32'h8000_0007;
      else                       cause = 32'h8000_000B;
      e = '0; e.hold = 1'b1; e.we = 1'b1;
      e.waddr = 32'h341; e.data = mepc;  q.push_back(e);
      e.waddr = 32'h342; e.data = cause; q.push_back(e);
      e.waddr = 32'h300;
      e.data = (mstatus & 32'hFFFF_FF77) | (((mstatus >> 3) & 32'd1) << 7);
      q.push_back(e);
      tgt = mtvec & 32'hFFFF_FFFC;
`ifdef CLINT_VECTORED_EN
      if (async_t && ((mtvec & 32'd3) == 32'd1)) tgt = tgt + 4 * (cause & 32'h7FFF_FFFF);
`endif
      e = '0; e.hold = 1'b1; e.asrt = 1'b1; e.addr = tgt; q.push_back(e);
      e = '0; q.push_back(e);
    end else if (mret_t) begin
      e = '0; e.hold = 1'b1; e.we = 1'b1; e.waddr = 32'h300;
      e.data = (mstatus & 32'hFFFF_FFF7) | 32'h80 | (((mstatus >> 7) & 32'd1) << 3);
      q.push_back(e);
      e = '0; e.hold = 1'b1; e.asrt = 1'b1; e.addr = mepc_csr; q.push_back(e);
      e = '0; q.push_back(e);
    end
    bus.inst_i = inst; bus.inst_addr_i = pc; bus.jump_flag_i = jf; bus.jump_addr_i = ja;
    bus.int_flag_i = flags; bus.global_int_en_i = en;
    bus.csr_mtvec_i = mtvec; bus.csr_mepc_i = mepc_csr; bus.csr_mstatus_i = mstatus;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        bus.int_flag_i  = 8'($urandom);
        bus.jump_flag_i = 1'($urandom);
        bus.jump_addr_i = $urandom;
        if (i == q.size() - 1) begin
          bus.inst_i = NOP; bus.global_int_en_i = 1'b0;
        end else begin
          bus.inst_i = junk_inst(); bus.global_int_en_i = 1'($urandom);
        end
      end
      @(negedge clk);
      check_outputs($sformatf("%s[%0d]", name, i), q[i]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    exp_t z;
    logic [31:0] inst_r;
    logic [7:0]  flags_r;
    z = '0;
    rst = 1'b1;
    bus.inst_i = NOP; bus.inst_addr_i = '0; bus.jump_flag_i = 1'b0; bus.jump_addr_i = '0;
    bus.int_flag_i = '0; bus.global_int_en_i = 1'b0;
    bus.csr_mtvec_i = '0; bus.csr_mepc_i = '0; bus.csr_mstatus_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs("reset", z);
    @(posedge clk); #1;

    run_txn("ecall",     32'h0000_0073, 32'h100, 1'b0, 32'h0,   8'h00, 1'b0, 32'h200, 32'h0,   32'h8);
    run_txn("mret",      32'h3020_0073, 32'h0,   1'b0, 32'h0,   8'h00, 1'b0, 32'h200, 32'h104, 32'h80);
    run_txn("timer_jmp", NOP,           32'h50,  1'b1, 32'h300, 8'h01, 1'b1, 32'h200, 32'h0,   32'h8);
    run_txn("irq_masked", NOP,          32'h60,  1'b0, 32'h0,   8'h02, 1'b0, 32'h200, 32'h0,   32'h8);
    run_txn("vec_timer", NOP,           32'h70,  1'b0, 32'h0,   8'h01, 1'b1, 32'h201, 32'h0,   32'h8);
    run_txn("ext_irq",   NOP,           32'h74,  1'b0, 32'h0,   8'h80, 1'b1, 32'h201, 32'h0,   32'h0);
    run_txn("ebreak_prio", 32'h0010_0073, 32'h80, 1'b1, 32'h400, 8'h01, 1'b1, 32'h201, 32'h0,  32'h88);
    run_txn("mret_prio", 32'h3020_0073, 32'h84,  1'b0, 32'h0,   8'hFF, 1'b1, 32'h200, 32'h1F0, 32'h0);

    // Reset in W_MCAUSE aborts the trap with no further write or redirect
    bus.inst_i = 32'h0000_0073; bus.inst_addr_i = 32'h40; bus.csr_mtvec_i = 32'h200;
    bus.int_flag_i = '0; bus.global_int_en_i = 1'b0;
    @(negedge clk); chk("rst_seq.acc_hold", 32'(bus.hold_flag_o), 32'd1);
    @(posedge clk); #1 bus.inst_i = NOP;
    @(negedge clk); chk("rst_seq.mepc_addr", bus.waddr_o, 32'h341);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("rst_seq.mcause_addr", bus.waddr_o, 32'h342);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_outputs($sformatf("rst_seq.after[%0d]", i), z);
      @(posedge clk); #1;
    end

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0: inst_r = 32'h0000_0073;
        1: inst_r = 32'h0010_0073;
        2: inst_r = 32'h3020_0073;
        3: inst_r = $urandom;
        default: inst_r = NOP;
      endcase
      flags_r = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_txn($sformatf("rnd%0d", n), inst_r, $urandom & 32'hFFFF_FFFC, 1'($urandom),
              $urandom & 32'hFFFF_FFFC, flags_r, 1'($urandom), $urandom, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
